// File: rtl/uart_rx_8x_pkg.sv
// rtl/uart_rx_8x_pkg.sv - shared receiver definitions: state encodings, oversampling constants, vote helper
package uart_rx_8x_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int OS_RATE     = 8;
  localparam int OS_W        = $clog2(OS_RATE);
  localparam int SAMPLE_LO   = 3;
  localparam int SAMPLE_HI   = 5;
  localparam int STOP_DECIDE = 5;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-stage synchroniser for the asynchronous rxd pin, resets to idle-high
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_8x.sv
// rtl/uart_rx_8x.sv - 8x-oversampling UART receiver with majority-vote bit recovery
module uart_rx_8x
  import uart_rx_8x_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 Baud8Tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int BC_W = 3;
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0] OS_LO     = OS_W'(SAMPLE_LO);
  localparam logic [OS_W-1:0] OS_HI     = OS_W'(SAMPLE_HI);
  localparam logic [OS_W-1:0] OS_STOP   = OS_W'(STOP_DECIDE);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [OS_W-1:0]      os_cnt_q;
  logic [OS_W-1:0]      os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q;
  logic [2:0]           vote_q;
  logic [2:0]           vote_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_frame_err_q;

  logic rxd_s;
  logic in_window;
  logic bit_val;
  logic stop_val;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(sys_clk),
    .rst_i(sys_rst),
    .d_i  (rxd),
    .q_o  (rxd_s)
  );

  // Samples shift in from the top, so after the window vote_q = {s5, s4, s3}.
  assign vote_d    = {rxd_s, vote_q[2:1]};
  assign os_cnt_d  = os_cnt_q + 1'b1;
  assign in_window = (os_cnt_q >= OS_LO) && (os_cnt_q <= OS_HI);
  assign bit_val   = maj3(vote_q);
  // The stop decision lands on the third sample itself, so vote on the live value.
  assign stop_val  = maj3(vote_d);
  assign shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      os_cnt_q       <= '0;
      bit_cnt_q      <= '0;
      vote_q         <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      if (Baud8Tick) begin
        if ((state_q inside {ST_START, ST_DATA, ST_STOP}) && in_window) begin
          vote_q <= vote_d;
        end
        case (state_q)
          ST_IDLE: begin
            if (!rxd_s) begin
              state_q  <= ST_START;
              os_cnt_q <= OS_W'(1);
            end
          end
          ST_START: begin
            os_cnt_q <= os_cnt_d;
            if (os_cnt_q == OS_LAST) begin
              if (bit_val) begin
                state_q <= ST_IDLE;
              end else begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end
            end
          end
          ST_DATA: begin
            os_cnt_q <= os_cnt_d;
            if (os_cnt_q == OS_LAST) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= ST_STOP;
              end
            end
          end
          ST_STOP: begin
            os_cnt_q <= os_cnt_d;
            if (os_cnt_q == OS_STOP) begin
              if (stop_val) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                state_q    <= ST_IDLE;
              end else begin
                rx_frame_err_q <= 1'b1;
                state_q        <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            // Hold here while the line stays low so a break cannot look like a new start.
            if (rxd_s) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8x.sv
// tb/tb_uart_rx_8x.sv - scoreboard bench for uart_rx_8x with one tick every 4 clocks
module tb_uart_rx_8x;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       Baud8Tick;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx_8x #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .Baud8Tick   (Baud8Tick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_pop;
  int   valid_cyc[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic tick_align();
    do @(posedge sys_clk); while (!Baud8Tick);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (32) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        rxd = b[i];
        repeat (16) @(posedge sys_clk);
        #1 rxd = ~b[i];
        repeat (4) @(posedge sys_clk);
        #1 rxd = b[i];
        repeat (12) @(posedge sys_clk);
        #1;
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(stop_bit);
  endtask

  initial begin
    Baud8Tick = 1'b0;
    forever begin
      repeat (3) @(posedge sys_clk);
      #1 Baud8Tick = 1'b1;
      @(posedge sys_clk);
      #1 Baud8Tick = 1'b0;
    end
  end

  always @(negedge sys_clk) begin
    if (rx_valid || rx_frame_err) begin
      if (rx_valid) begin
        check("pulse_exclusive", {31'b0, rx_frame_err}, 32'd0);
        valid_cyc.push_back(cyc);
      end
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, rx_valid, rx_frame_err}, 32'd0);
      end else begin
        e_pop = exp_q.pop_front();
        check("pulse_kind_is_err", {31'b0, rx_frame_err}, {31'b0, e_pop.is_err});
        check("pulse_rx_data", {24'b0, rx_data}, {24'b0, e_pop.data});
        check("pulse_rx_busy", {31'b0, rx_busy}, {31'b0, e_pop.is_err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1;
    rxd     = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
    check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    repeat (20) @(posedge sys_clk);

    expect_byte(8'h55);
    tick_align();
    send_frame(8'h55, 1'b1, -1);
    repeat (64) @(posedge sys_clk);
    check("t55_pending", exp_q.size(), 32'd0);
    check("t55_valid_count", valid_cyc.size(), 32'd1);

    expect_byte(8'hA3);
    expect_byte(8'h00);
    tick_align();
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h00, 1'b1, -1);
    repeat (64) @(posedge sys_clk);
    check("b2b_pending", exp_q.size(), 32'd0);
    check("b2b_valid_count", valid_cyc.size(), 32'd3);
    if (valid_cyc.size() == 3) check("b2b_gap", valid_cyc[2] - valid_cyc[1], 32'd320);

    tick_align();
    rxd = 1'b0;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    check("false_start_busy_high", {31'b0, rx_busy}, 32'd1);
    rxd = 1'b1;
    repeat (40) @(posedge sys_clk);
    @(negedge sys_clk);
    check("false_start_busy_low", {31'b0, rx_busy}, 32'd0);
    check("false_start_valid_count", valid_cyc.size(), 32'd3);

    expect_ferr(8'h00);
    tick_align();
    send_frame(8'h3C, 1'b0, -1);
    repeat (80) @(posedge sys_clk);
    @(negedge sys_clk);
    check("ferr_busy_in_break", {31'b0, rx_busy}, 32'd1);
    check("ferr_pending", exp_q.size(), 32'd0);
    check("ferr_rx_data_held", {24'b0, rx_data}, 32'd0);
    repeat (16) @(posedge sys_clk);
    #1 rxd = 1'b1;
    repeat (16) @(posedge sys_clk);
    @(negedge sys_clk);
    check("ferr_busy_released", {31'b0, rx_busy}, 32'd0);
    repeat (32) @(posedge sys_clk);

    expect_byte(8'h96);
    tick_align();
    send_frame(8'h96, 1'b1, 2);
    repeat (64) @(posedge sys_clk);
    check("glitch_pending", exp_q.size(), 32'd0);

    tick_align();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b1;
    repeat (16) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_mid_busy_before", {31'b0, rx_busy}, 32'd1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_mid_busy_after", {31'b0, rx_busy}, 32'd0);
    check("rst_mid_rx_data", {24'b0, rx_data}, 32'd0);
    repeat (64) @(posedge sys_clk);

    expect_byte(8'hF0);
    tick_align();
    send_frame(8'hF0, 1'b1, -1);
    repeat (64) @(posedge sys_clk);
    check("f0_pending", exp_q.size(), 32'd0);
    check("final_valid_count", valid_cyc.size(), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
